// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: fetch-stage controller. It owns the PC, drives the instruction
// memory address and loads the IF/ID pipeline register. It sequences fetch through
// init, run, stall, redirect and end-of-memory halt.
// Optional feature macro: FETCH_WRAP_EN. When it is defined, the PC wraps modulo
// DEPTH and there is no halt. When it is undefined, a PC at or past DEPTH halts fetch.
module instr_fetch_ctrl #(
  parameter int unsigned N        = 32,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned RESET_PC = 0
) (
  input  logic         clk,
  input  logic         reset,
  output logic [N-1:0] imem_addr,
  input  logic [N-1:0] imem_data,
  input  logic         stall,
  input  logic         redirect_valid,
  input  logic [N-1:0] redirect_target,
  output logic [N-1:0] if_id_instr,
  output logic [N-1:0] if_id_pc,
  output logic         if_id_valid,
  output logic         halted,
  output logic [N-1:0] fetch_count
);

  localparam logic [N-1:0] DEPTH_W    = N'(DEPTH);
  localparam logic [N-1:0] RESET_PC_W = N'(RESET_PC);

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t       state, state_nxt;
  logic [N-1:0] pc, pc_nxt;
  logic [N-1:0] instr_nxt, ifpc_nxt, cnt_nxt;
  logic         valid_nxt, halted_nxt;
  logic [N-1:0] cand, cand_fold;
  logic         cand_oob;

  assign imem_addr = pc;

  // Candidate next PC (redirect or sequential), folded or flagged by the bounds rule
  always_comb begin
    cand = redirect_valid ? redirect_target : pc + N'(1);
`ifdef FETCH_WRAP_EN
    cand_fold = (cand >= DEPTH_W) ? N'(cand % DEPTH_W) : cand;
    cand_oob  = 1'b0;
`else
    cand_fold = cand;
    cand_oob  = (cand >= DEPTH_W);
`endif
  end

  // Next-state and next-register values; hold by default
  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    instr_nxt  = if_id_instr;
    ifpc_nxt   = if_id_pc;
    valid_nxt  = if_id_valid;
    cnt_nxt    = fetch_count;
    halted_nxt = halted;
    case (state)
      S_INIT: begin
        instr_nxt = '0;
        ifpc_nxt  = '0;
        valid_nxt = 1'b0;
        state_nxt = S_RUN;
      end
      S_RUN: begin
        if (redirect_valid) begin
          // Redirect wins over stall and leaves a single bubble behind it
          instr_nxt = '0;
          ifpc_nxt  = '0;
          valid_nxt = 1'b0;
          pc_nxt    = cand_fold;
          if (cand_oob) begin
            state_nxt  = S_HALT;
            halted_nxt = 1'b1;
          end
        end else if (!stall) begin
          instr_nxt = imem_data;
          ifpc_nxt  = pc;
          valid_nxt = 1'b1;
          cnt_nxt   = fetch_count + N'(1);
          pc_nxt    = cand_fold;
          if (cand_oob) begin
            state_nxt  = S_HALT;
            halted_nxt = 1'b1;
          end
        end
      end
      S_HALT: begin
        // PC keeps its out-of-range value; only an in-range redirect restarts fetch
        instr_nxt  = '0;
        ifpc_nxt   = '0;
        valid_nxt  = 1'b0;
        halted_nxt = 1'b1;
        if (redirect_valid && (redirect_target < DEPTH_W)) begin
          pc_nxt     = redirect_target;
          state_nxt  = S_RUN;
          halted_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt = S_INIT;
      end
    endcase
  end

  // State, PC and registered outputs with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_INIT;
      pc          <= RESET_PC_W;
      if_id_instr <= '0;
      if_id_pc    <= '0;
      if_id_valid <= 1'b0;
      halted      <= 1'b0;
      fetch_count <= '0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      if_id_instr <= instr_nxt;
      if_id_pc    <= ifpc_nxt;
      if_id_valid <= valid_nxt;
      halted      <= halted_nxt;
      fetch_count <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl. Memory word k holds 0x1000_0000 + k.
module tb_instr_fetch_ctrl;

  localparam int unsigned N     = 32;
  localparam int unsigned DEPTH = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] imem_addr;
  logic [N-1:0] imem_data;
  logic         stall;
  logic         redirect_valid;
  logic [N-1:0] redirect_target;
  logic [N-1:0] if_id_instr;
  logic [N-1:0] if_id_pc;
  logic         if_id_valid;
  logic         halted;
  logic [N-1:0] fetch_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign imem_data = 32'h1000_0000 + imem_addr;

  instr_fetch_ctrl #(.N(N), .DEPTH(DEPTH), .RESET_PC(0)) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_addr       (imem_addr),
    .imem_data       (imem_data),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .if_id_instr     (if_id_instr),
    .if_id_pc        (if_id_pc),
    .if_id_valid     (if_id_valid),
    .halted          (halted),
    .fetch_count     (fetch_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock edge and settle past it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_valid(input string tag, input logic [31:0] pc, input logic [31:0] cnt);
    check_eq({tag, "_valid"}, 32'(if_id_valid), 32'd1);
    check_eq({tag, "_pc"},    if_id_pc, pc);
    check_eq({tag, "_instr"}, if_id_instr, 32'h1000_0000 + pc);
    check_eq({tag, "_cnt"},   fetch_count, cnt);
  endtask

  task automatic check_bubble(input string tag);
    check_eq({tag, "_valid"}, 32'(if_id_valid), 32'd0);
    check_eq({tag, "_pc"},    if_id_pc, 32'd0);
    check_eq({tag, "_instr"}, if_id_instr, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    step(); step();
    reset = 1'b0;
    check_bubble("rst");
    check_eq("rst_halted", 32'(halted), 32'd0);
    check_eq("rst_cnt", fetch_count, 32'd0);
    check_eq("rst_addr", imem_addr, 32'd0);

    // Edge 1: S_INIT, still a bubble
    step();
    check_bubble("init");
    check_eq("init_addr", imem_addr, 32'd0);

    // Edges 2..4 deliver pc 0,1,2
    step(); check_valid("f0", 32'd0, 32'd1);
    step(); check_valid("f1", 32'd1, 32'd2);
    step(); check_valid("f2", 32'd2, 32'd3);

    // Stall for three cycles holds IF/ID and count
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_valid("stall", 32'd2, 32'd3);
      check_eq("stall_addr", imem_addr, 32'd3);
    end
    stall = 1'b0;
    step(); check_valid("f3", 32'd3, 32'd4);

    // Redirect to 12 together with stall: bubble, then pc 12
    redirect_valid = 1'b1; redirect_target = 32'd12; stall = 1'b1;
    step();
    redirect_valid = 1'b0; stall = 1'b0;
    check_bubble("redir");
    check_eq("redir_cnt", fetch_count, 32'd4);
    check_eq("redir_addr", imem_addr, 32'd12);
    step(); check_valid("tgt12", 32'd12, 32'd5);

    // Sequential run to the last word
    for (int k = 13; k <= 31; k++) begin
      step();
      check_valid("seq", 32'(k), 32'(k - 7));
    end

`ifdef FETCH_WRAP_EN
    check_eq("wrap_halted31", 32'(halted), 32'd0);
    check_eq("wrap_addr", imem_addr, 32'd0);
    step(); check_valid("wrap0", 32'd0, 32'd25);
    check_eq("wrap_halted0", 32'(halted), 32'd0);
    step(); check_valid("wrap1", 32'd1, 32'd26);
    redirect_valid = 1'b1; redirect_target = 32'd40;
    step();
    redirect_valid = 1'b0;
    check_bubble("wrap_redir");
    check_eq("wrap_redir_addr", imem_addr, 32'd8);
    step(); check_valid("wrap_tgt8", 32'd8, 32'd27);
    check_eq("wrap_halted_end", 32'(halted), 32'd0);
`else
    check_eq("halt_set", 32'(halted), 32'd1);
    check_eq("halt_addr", imem_addr, 32'd32);
    step();
    check_bubble("halt_b1");
    check_eq("halt_b1_h", 32'(halted), 32'd1);
    check_eq("halt_b1_cnt", fetch_count, 32'd24);
    stall = 1'b1;
    step();
    stall = 1'b0;
    check_bubble("halt_stall");
    check_eq("halt_stall_addr", imem_addr, 32'd32);
    redirect_valid = 1'b1; redirect_target = 32'd40;
    step();
    check_eq("halt_oob_h", 32'(halted), 32'd1);
    check_eq("halt_oob_addr", imem_addr, 32'd32);
    redirect_target = 32'd5;
    step();
    redirect_valid = 1'b0;
    check_eq("halt_exit_h", 32'(halted), 32'd0);
    check_bubble("halt_exit");
    check_eq("halt_exit_addr", imem_addr, 32'd5);
    step(); check_valid("tgt5", 32'd5, 32'd25);
`endif

    // Reset during a redirect cycle
    redirect_valid = 1'b1; redirect_target = 32'd20; reset = 1'b1;
    step();
    reset = 1'b0; redirect_valid = 1'b0;
    check_bubble("rst2");
    check_eq("rst2_halted", 32'(halted), 32'd0);
    check_eq("rst2_cnt", fetch_count, 32'd0);
    check_eq("rst2_addr", imem_addr, 32'd0);
    step();
    check_bubble("rst2_init");
    step(); check_valid("rst2_f0", 32'd0, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_ctrl.md
# instr_fetch_ctrl

Fetch-stage controller for the pipelined MIPS core. It owns the program counter, drives the word address into the combinational-read instruction memory, and loads the IF/ID pipeline register. It sequences fetch through reset, run, stall, branch/jump redirect and end-of-program halt. It sits between the instruction memory and the decode stage, and takes stall and redirect from the hazard unit and the branch/jump resolution logic.

## Interface
- `N`, 32, data and address width.
- `DEPTH`, 32, number of instruction-memory words; valid word addresses are 0..DEPTH-1.
- `RESET_PC`, 0, word address fetched first after reset.

- `clk` input 1: rising-edge clock.
- `reset` input 1: reset, synchronous, active-high.
- `imem_addr` output N: word index to instruction memory; equals the `pc` register.
- `imem_data` input N: instruction returned combinationally for `imem_addr`.
- `stall` input 1: hold PC and IF/ID this cycle.
- `redirect_valid` input 1: taken branch or jump resolved this cycle.
- `redirect_target` input N: word address of the redirect.
- `if_id_instr` output N: registered instruction to decode.
- `if_id_pc` output N: registered word address of `if_id_instr`.
- `if_id_valid` output 1: `if_id_instr` is a real instruction, not a bubble.
- `halted` output 1: fetch is halted at end of memory.
- `fetch_count` output N: number of instructions delivered with valid=1; wraps at 2^N.

## Operation
- States:
  - `S_INIT`: one cycle after reset deasserts; instruction memory output is not yet trusted.
  - `S_RUN`: normal fetch.
  - `S_HALT`: PC has left 0..DEPTH-1.
- Reset (any state, any cycle, including mid-stall or mid-redirect): `pc`=RESET_PC, state=`S_INIT`.
  - `if_id_instr`=0, `if_id_pc`=0, `if_id_valid`=0, `halted`=0, `fetch_count`=0.
- `S_INIT` → `S_RUN` unconditionally. IF/ID is held as a bubble and `pc` is unchanged.
- `S_RUN`, per edge, in priority order:
  1. `redirect_valid`: `pc`←target, then apply the bounds rule. IF/ID←bubble (instr=0, valid=0, pc=0). `fetch_count` is unchanged. Redirect overrides `stall`.
  2. `stall`: all registers hold.
  3. Otherwise: `if_id_instr`←`imem_data`, `if_id_pc`←`pc`, `if_id_valid`←1, `fetch_count`+1, `pc`←`pc`+1, then apply the bounds rule.
- Bounds rule applies whenever the next `pc` is ≥ DEPTH (see Configuration).
- `S_HALT`:
  - `halted`=1. IF/ID is a bubble every cycle and `pc` holds its out-of-range value.
  - `redirect_valid` with target < DEPTH: `pc`←target, → `S_RUN`, `halted`=0.
  - Redirect with target ≥ DEPTH: stay in `S_HALT`.
  - `stall` is ignored.
- PC arithmetic is N-bit unsigned. `imem_addr` always equals `pc`, including in `S_HALT`. The downstream memory must not be indexed out of range there, so the decode stage qualifies on `if_id_valid`.

## Timing
- Latency: the instruction at word A appears on `if_id_instr` on the edge after the edge where `pc`=A, i.e. one cycle.
- After reset deasserts, the first valid IF/ID (A=RESET_PC) appears on the 2nd edge: one cycle in `S_INIT`, one fetch edge.
- Redirect penalty: the edge with `redirect_valid` produces one bubble. The target instruction is valid on the following edge, provided `stall`=0.
- Stall: while `stall`=1 and no redirect, IF/ID, `pc` and `fetch_count` are bit-for-bit stable.
- All outputs are registered except `imem_addr`, which is a direct wire from the `pc` register.

## Configuration
- `FETCH_WRAP_EN`:
  - Defined: the next `pc` ≥ DEPTH is reduced modulo DEPTH. Sequential fetch wraps DEPTH-1 → 0, and an out-of-range redirect target maps to target mod DEPTH. `S_HALT` is unreachable and `halted` stays 0.
  - Undefined: the next `pc` ≥ DEPTH is stored unchanged and the state → `S_HALT` on that edge.

## Test plan
- Reset, RESET_PC=0, memory word k = 0x1000_0000+k, no stall → `if_id_valid`=0 for edge 1. Edges 2..5 deliver `if_id_pc`=0,1,2,3 with matching instructions. `fetch_count`=4.
- Stall high for 3 cycles while `if_id_pc`=2 → IF/ID stays at pc 2 and `fetch_count` is constant. Release → pc 3 on the next edge.
- Redirect to target 12 with `stall`=1 in the same cycle → bubble next edge, then `if_id_pc`=12 valid. `fetch_count` is not incremented for the bubble.
- Run to word 31, macro undefined → after pc 31 is delivered, `halted`=1 and bubbles continue. Redirect to 5 → `halted`=0, then `if_id_pc`=5.
- Same run with `FETCH_WRAP_EN` defined → `if_id_pc` sequence 30,31,0,1 and `halted` never asserts. Redirect to 40 → `if_id_pc`=8.
- Reset asserted mid-stream during a redirect cycle → the next edge shows all outputs zero and state `S_INIT`. The first valid instruction is again at RESET_PC.
